// File: rtl/rwt_tag_extract_mw.sv
// Escaped AXI-Stream tag extractor: escape + header word introduce a tag of
// 1..2^LEN_WIDTH payload words that are forwarded flagged as tag words.
module rwt_tag_extract_mw #(
  parameter int DWIDTH     = 64,
  parameter int TYPE_WIDTH = 7,
  parameter int LEN_WIDTH  = 4,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  areset,
  input  logic                  use_tags,
  input  logic [DWIDTH-1:0]     tag_escape,
  input  logic [DWIDTH-1:0]     s_axi_data,
  input  logic                  s_axi_valid,
  output logic                  s_axi_ready,
  input  logic                  s_axi_last,
  output logic [DWIDTH-1:0]     m_axi_data,
  output logic                  m_axi_valid,
  input  logic                  m_axi_ready,
  output logic                  m_axi_last,
  output logic                  m_axi_tag_valid,
  output logic [TYPE_WIDTH-1:0] m_axi_tag_type,
  output logic                  m_axi_tag_first,
  output logic [CNT_WIDTH-1:0]  tag_count,
  output logic                  err_truncated
);

  localparam int RW = LEN_WIDTH + 1;

  typedef enum logic [1:0] {
    ST_PASS    = 2'd0,
    ST_HDR     = 2'd1,
    ST_PAYLOAD = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [RW-1:0]         rem_q, rem_d;
  logic [TYPE_WIDTH-1:0] type_q, type_d;
  logic                  first_q, first_d;

  logic [DWIDTH-1:0]     data_q;
  logic                  valid_q, last_q, tv_q, tf_q, err_q;
  logic [TYPE_WIDTH-1:0] tt_q;
  logic [CNT_WIDTH-1:0]  count_q;

  logic                  accept_s, is_esc_s;
  logic [TYPE_WIDTH-1:0] hdr_type_s;
  logic [RW-1:0]         hdr_len_s;
  logic                  emit_s, trunc_s, done_s, o_tv_s, o_tf_s;
  logic [DWIDTH-1:0]     o_data_s;
  logic [TYPE_WIDTH-1:0] o_type_s;

  assign s_axi_ready = !valid_q || m_axi_ready;
  assign accept_s    = s_axi_valid && s_axi_ready;
  assign is_esc_s    = (s_axi_data == tag_escape);
  assign hdr_type_s  = s_axi_data[TYPE_WIDTH-1:0];
  assign hdr_len_s   = {1'b0, s_axi_data[TYPE_WIDTH+LEN_WIDTH-1:TYPE_WIDTH]} + RW'(1);

  // State register plus tag context; everything advances only on accepted beats.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q <= ST_PASS;
      rem_q   <= {RW{1'b0}};
      type_q  <= {TYPE_WIDTH{1'b0}};
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      type_q  <= type_d;
      first_q <= first_d;
    end
  end

  // Next-state and tag-context logic.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    type_d  = type_q;
    first_d = first_q;
    case (state_q)
      ST_PASS: begin
        if (accept_s && use_tags && is_esc_s && !s_axi_last) begin
          state_d = ST_HDR;
        end else begin
          state_d = ST_PASS;
        end
      end
      ST_HDR: begin
        if (!accept_s) begin
          state_d = ST_HDR;
        end else if (hdr_type_s == {TYPE_WIDTH{1'b0}} || s_axi_last) begin
          state_d = ST_PASS;
        end else begin
          state_d = ST_PAYLOAD;
          type_d  = hdr_type_s;
          rem_d   = hdr_len_s;
          first_d = 1'b1;
        end
      end
      ST_PAYLOAD: begin
        if (accept_s) begin
          first_d = 1'b0;
          rem_d   = rem_q - RW'(1);
          if (rem_q == RW'(1) || s_axi_last) begin
            state_d = ST_PASS;
          end else begin
            state_d = ST_PAYLOAD;
          end
        end else begin
          state_d = ST_PAYLOAD;
        end
      end
      default: state_d = ST_PASS;
    endcase
  end

  // Output decode: what the accepted beat produces, plus completion/abort events.
  always_comb begin
    emit_s   = 1'b0;
    trunc_s  = 1'b0;
    done_s   = 1'b0;
    o_data_s = s_axi_data;
    o_tv_s   = 1'b0;
    o_tf_s   = 1'b0;
    o_type_s = {TYPE_WIDTH{1'b0}};
    case (state_q)
      ST_PASS: begin
        if (accept_s && use_tags && is_esc_s) begin
          trunc_s = s_axi_last;
        end else begin
          emit_s = accept_s;
        end
      end
      ST_HDR: begin
        if (accept_s && hdr_type_s == {TYPE_WIDTH{1'b0}}) begin
          emit_s   = 1'b1;
          o_data_s = tag_escape;
        end else begin
          trunc_s = accept_s && s_axi_last;
        end
      end
      ST_PAYLOAD: begin
        if (accept_s) begin
          emit_s   = 1'b1;
          o_tv_s   = 1'b1;
          o_tf_s   = first_q;
          o_type_s = type_q;
          done_s   = (rem_q == RW'(1));
          trunc_s  = (rem_q != RW'(1)) && s_axi_last;
        end else begin
          emit_s = 1'b0;
        end
      end
      default: emit_s = 1'b0;
    endcase
  end

  // Output register, tag counter and truncation pulse.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      valid_q <= 1'b0;
      data_q  <= {DWIDTH{1'b0}};
      last_q  <= 1'b0;
      tv_q    <= 1'b0;
      tt_q    <= {TYPE_WIDTH{1'b0}};
      tf_q    <= 1'b0;
      count_q <= {CNT_WIDTH{1'b0}};
      err_q   <= 1'b0;
    end else begin
      if (s_axi_ready) begin
        valid_q <= emit_s;
        if (emit_s) begin
          data_q <= o_data_s;
          last_q <= s_axi_last;
          tv_q   <= o_tv_s;
          tt_q   <= o_type_s;
          tf_q   <= o_tf_s;
        end
      end
      if (done_s) begin
        count_q <= count_q + CNT_WIDTH'(1);
      end
      err_q <= trunc_s;
    end
  end

  assign m_axi_valid     = valid_q;
  assign m_axi_data      = data_q;
  assign m_axi_last      = last_q;
  assign m_axi_tag_valid = tv_q;
  assign m_axi_tag_type  = tt_q;
  assign m_axi_tag_first = tf_q;
  assign tag_count       = count_q;
  assign err_truncated   = err_q;

endmodule

// File: tb/tb_rwt_tag_extract_mw.sv
// Bench for rwt_tag_extract_mw: directed vector tables, a randomized run with
// backpressure checked against a lookahead parsing model, and a mid-tag reset.
module tb_rwt_tag_extract_mw;

  localparam logic [63:0] ESC = 64'hAAAA_AAAA_AAAA_AAAA;

  logic        clk = 1'b0;
  logic        areset, use_tags, s_valid, s_ready, s_last;
  logic        m_valid, m_ready, m_last, m_tv, m_tf, err;
  logic [63:0] s_data, m_data;
  logic [6:0]  m_type;
  logic [31:0] tag_count;

  rwt_tag_extract_mw dut (
    .clk(clk), .areset(areset), .use_tags(use_tags), .tag_escape(ESC),
    .s_axi_data(s_data), .s_axi_valid(s_valid), .s_axi_ready(s_ready), .s_axi_last(s_last),
    .m_axi_data(m_data), .m_axi_valid(m_valid), .m_axi_ready(m_ready), .m_axi_last(m_last),
    .m_axi_tag_valid(m_tv), .m_axi_tag_type(m_type), .m_axi_tag_first(m_tf),
    .tag_count(tag_count), .err_truncated(err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [63:0] d; logic last; } in_t;
  typedef struct { logic [63:0] d; logic tv; logic [6:0] ty; logic f; logic l; } out_t;
  typedef struct {
    int grp; logic ut; logic [63:0] d; logic last;
    logic has; logic [63:0] od; logic tv; logic [6:0] ty; logic f; logic ol;
  } vec_t;

  in_t  in_q[$];
  out_t exp_q[$];
  out_t got_q[$];
  vec_t vecs[$];
  int   checks = 0, fails = 0;
  int   exp_err, exp_tags, exp_total;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(int g, logic ut, logic [63:0] d, logic last, logic has,
                              logic [63:0] od, logic tv, logic [6:0] ty, logic f, logic ol);
    vec_t v;
    v.grp = g; v.ut = ut; v.d = d; v.last = last; v.has = has;
    v.od = od; v.tv = tv; v.ty = ty; v.f = f; v.ol = ol;
    return v;
  endfunction

  task automatic push_exp(input logic [63:0] d, input logic tv, input logic [6:0] ty,
                          input logic f, input logic l);
    out_t o;
    o.d = d; o.tv = tv; o.ty = ty; o.f = f; o.l = l;
    exp_q.push_back(o);
  endtask

  // Reference: walk the whole word list, looking ahead at the header.
  task automatic model(input bit ut);
    int i, n, k, len;
    bit done;
    logic [63:0] h;
    logic [6:0] typ;
    exp_q.delete(); exp_err = 0; exp_tags = 0;
    n = in_q.size(); i = 0;
    while (i < n) begin
      if (!ut || in_q[i].d != ESC) begin
        push_exp(in_q[i].d, 1'b0, 7'd0, 1'b0, in_q[i].last); i++;
      end else if (in_q[i].last) begin
        exp_err++; i++;
      end else if (i + 1 >= n) begin
        i = n;
      end else begin
        h = in_q[i+1].d; typ = h[6:0]; len = int'(h[10:7]) + 1;
        if (typ == 7'd0) begin
          push_exp(ESC, 1'b0, 7'd0, 1'b0, in_q[i+1].last); i += 2;
        end else if (in_q[i+1].last) begin
          exp_err++; i += 2;
        end else begin
          i += 2; k = 0; done = 0;
          while (!done && i < n) begin
            push_exp(in_q[i].d, 1'b1, typ, k == 0, in_q[i].last);
            k++;
            if (k == len) begin exp_tags++; done = 1; end
            else if (in_q[i].last) begin exp_err++; done = 1; end
            i++;
          end
        end
      end
    end
  endtask

  task automatic run_stream(input bit ut, input int rdy_pct, input int vld_pct, input string nm);
    int idx = 0, cyc = 0, tail = 0, errs = 0;
    bit acc, stall = 0;
    out_t held, o;
    got_q.delete();
    use_tags = ut;
    while (cyc < 20000 && tail < 4) begin
      @(negedge clk);
      if (idx < in_q.size()) begin
        s_valid = ($urandom_range(0, 99) < vld_pct);
        s_data  = in_q[idx].d;
        s_last  = in_q[idx].last;
      end else begin
        s_valid = 1'b0; s_last = 1'b0;
      end
      m_ready = ($urandom_range(0, 99) < rdy_pct) || (idx >= in_q.size() && tail > 0);
      #1;
      if (stall) begin
        chk({nm, " hold_data"}, m_data, held.d);
        chk({nm, " hold_flags"}, {m_valid, m_tv, m_type, m_tf, m_last},
            {1'b1, held.tv, held.ty, held.f, held.l});
      end
      o.d = m_data; o.tv = m_tv; o.ty = m_type; o.f = m_tf; o.l = m_last;
      if (m_valid && m_ready) got_q.push_back(o);
      stall = m_valid && !m_ready;
      held = o;
      if (err) errs++;
      acc = s_valid && s_ready;
      @(posedge clk);
      if (acc) idx++;
      if (idx >= in_q.size() && got_q.size() >= exp_q.size()) tail++;
      cyc++;
    end
    if (cyc >= 20000) begin
      fails++; checks++;
      $display("FAIL %s timeout: sent %0d of %0d, got %0d beats", nm, idx, in_q.size(), got_q.size());
    end
    exp_total += exp_tags;
    chk({nm, " beats"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk($sformatf("%s data[%0d]", nm, i), got_q[i].d, exp_q[i].d);
      chk($sformatf("%s flags[%0d] tv/type/first/last", nm, i),
          {got_q[i].tv, got_q[i].ty, got_q[i].f, got_q[i].l},
          {exp_q[i].tv, exp_q[i].ty, exp_q[i].f, exp_q[i].l});
    end
    chk({nm, " err_pulses"}, errs, exp_err);
    chk({nm, " tag_count"}, tag_count, exp_total);
  endtask

  int          g_err[7]  = '{0, 0, 0, 1, 1, 1, 0};
  int          g_tags[7] = '{0, 1, 0, 0, 0, 0, 1};
  logic [63:0] w, h;
  int          ntags;

  initial begin
    areset = 1'b1; use_tags = 1'b0; s_valid = 1'b0; s_data = 64'd0; s_last = 1'b0;
    m_ready = 1'b0; exp_total = 0;
    // Directed tables: {group, use_tags, in word, in last, has out, out word, tv, type, first, last}
    vecs.push_back(mk(0, 0, 64'd1, 0, 1, 64'd1, 0, 7'd0, 0, 0));
    vecs.push_back(mk(0, 0, 64'd2, 0, 1, 64'd2, 0, 7'd0, 0, 0));
    vecs.push_back(mk(0, 0, ESC,   1, 1, ESC,   0, 7'd0, 0, 1));
    vecs.push_back(mk(1, 1, 64'd5, 0, 1, 64'd5, 0, 7'd0, 0, 0));
    vecs.push_back(mk(1, 1, ESC,   0, 0, 64'd0, 0, 7'd0, 0, 0));
    vecs.push_back(mk(1, 1, 64'h103, 0, 0, 64'd0, 0, 7'd0, 0, 0));
    vecs.push_back(mk(1, 1, 64'h1000, 0, 1, 64'h1000, 1, 7'd3, 1, 0));
    vecs.push_back(mk(1, 1, ESC,      0, 1, ESC,      1, 7'd3, 0, 0));
    vecs.push_back(mk(1, 1, 64'h1002, 1, 1, 64'h1002, 1, 7'd3, 0, 1));
    vecs.push_back(mk(2, 1, ESC,     0, 0, 64'd0, 0, 7'd0, 0, 0));
    vecs.push_back(mk(2, 1, 64'hF80, 0, 1, ESC,   0, 7'd0, 0, 0));
    vecs.push_back(mk(2, 1, 64'd7,   0, 1, 64'd7, 0, 7'd0, 0, 0));
    vecs.push_back(mk(3, 1, ESC,      0, 0, 64'd0, 0, 7'd0, 0, 0));
    vecs.push_back(mk(3, 1, 64'h185,  0, 0, 64'd0, 0, 7'd0, 0, 0));
    vecs.push_back(mk(3, 1, 64'h2000, 0, 1, 64'h2000, 1, 7'd5, 1, 0));
    vecs.push_back(mk(3, 1, 64'h2001, 1, 1, 64'h2001, 1, 7'd5, 0, 1));
    vecs.push_back(mk(3, 1, 64'd9,    0, 1, 64'd9,    0, 7'd0, 0, 0));
    vecs.push_back(mk(4, 1, ESC,      1, 0, 64'd0,  0, 7'd0, 0, 0));
    vecs.push_back(mk(4, 1, 64'h33,   0, 1, 64'h33, 0, 7'd0, 0, 0));
    vecs.push_back(mk(5, 1, ESC,      0, 0, 64'd0,  0, 7'd0, 0, 0));
    vecs.push_back(mk(5, 1, 64'h103,  1, 0, 64'd0,  0, 7'd0, 0, 0));
    vecs.push_back(mk(5, 1, 64'h44,   0, 1, 64'h44, 0, 7'd0, 0, 0));
    vecs.push_back(mk(6, 1, ESC,      0, 0, 64'd0,  0, 7'd0, 0, 0));
    vecs.push_back(mk(6, 1, 64'h781,  0, 0, 64'd0,  0, 7'd0, 0, 0));
    for (int k = 0; k < 16; k++)
      vecs.push_back(mk(6, 1, 64'h3000 + k, k == 15, 1, 64'h3000 + k, 1, 7'd1, k == 0, k == 15));
    vecs.push_back(mk(6, 1, 64'h55, 0, 1, 64'h55, 0, 7'd0, 0, 0));

    repeat (3) @(negedge clk);
    #1;
    chk("reset outputs", {m_valid, m_last, m_tv, m_type, m_tf, err}, 12'd0);
    chk("reset data", m_data, 64'd0);
    chk("reset tag_count", tag_count, 32'd0);
    @(negedge clk) areset = 1'b0;

    for (int g = 0; g < 7; g++) begin
      bit ut;
      in_q.delete(); exp_q.delete(); ut = 1'b0;
      foreach (vecs[i]) if (vecs[i].grp == g) begin
        in_t t;
        out_t o;
        t.d = vecs[i].d; t.last = vecs[i].last; in_q.push_back(t); ut = vecs[i].ut;
        if (vecs[i].has) begin
          o.d = vecs[i].od; o.tv = vecs[i].tv; o.ty = vecs[i].ty; o.f = vecs[i].f; o.l = vecs[i].ol;
          exp_q.push_back(o);
        end
      end
      exp_err = g_err[g]; exp_tags = g_tags[g];
      run_stream(ut, 100, 100, $sformatf("dir%0d", g));
    end

    // Randomized mixed traffic: 100 complete tags amid plain words and literal escapes.
    in_q.delete(); ntags = 0;
    for (int t = 0; t < 100; t++) begin
      in_t x;
      for (int p = $urandom_range(0, 5); p > 0; p--) begin
        w = {$urandom, $urandom};
        if (w == ESC) w = 64'd1;
        x.d = w; x.last = ($urandom_range(0, 9) == 0); in_q.push_back(x);
      end
      if ($urandom_range(0, 4) == 0) begin
        x.d = ESC; x.last = 1'b0; in_q.push_back(x);
        h = {$urandom, $urandom}; h[6:0] = 7'd0;
        x.d = h; x.last = $urandom_range(0, 1); in_q.push_back(x);
      end
      x.d = ESC; x.last = 1'b0; in_q.push_back(x);
      h = {$urandom, $urandom};
      h[10:7] = 4'($urandom_range(0, 15));
      h[6:0]  = 7'($urandom_range(1, 127));
      x.d = h; x.last = 1'b0; in_q.push_back(x);
      for (int k = 0; k <= int'(h[10:7]); k++) begin
        x.d = ($urandom_range(0, 7) == 0) ? ESC : {$urandom, $urandom};
        x.last = (k == int'(h[10:7])) && ($urandom_range(0, 3) == 0);
        in_q.push_back(x);
      end
      ntags++;
    end
    model(1'b1);
    chk("random model tags", exp_tags, ntags);
    run_stream(1'b1, 50, 80, "random");

    // Reset mid-payload with two words of a four-word tag still outstanding.
    in_q.delete();
    begin
      in_t x;
      x.last = 1'b0;
      x.d = ESC;      in_q.push_back(x);
      x.d = 64'h183;  in_q.push_back(x);
      x.d = 64'h4000; in_q.push_back(x);
      x.d = 64'h4001; in_q.push_back(x);
    end
    model(1'b1);
    run_stream(1'b1, 100, 100, "pre_reset");
    @(negedge clk);
    areset = 1'b1; m_ready = 1'b0;
    #1;
    chk("in reset m_axi_valid", m_valid, 64'd0);
    chk("in reset tag_count", tag_count, 64'd0);
    @(negedge clk);
    #1;
    chk("in reset m_axi_valid 2", m_valid, 64'd0);
    areset = 1'b0; exp_total = 0;
    in_q.delete();
    begin
      in_t x;
      x.d = 64'h1234; x.last = 1'b1; in_q.push_back(x);
    end
    exp_q.delete(); push_exp(64'h1234, 1'b0, 7'd0, 1'b0, 1'b1);
    exp_err = 0; exp_tags = 0;
    run_stream(1'b1, 100, 100, "post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/rwt_tag_extract_mw.md
Name: rwt_tag_extract_mw

Overview:
Parametrised successor of the single-word tag extractor. It parses an escaped AXI-Stream in which an escape word introduces a header word carrying a tag type and a payload length, so one tag spans 1..2^LEN_WIDTH payload words. Payload words are forwarded on the output stream, flagged as tag words. Ordinary data passes through unchanged, and an escaped escape is emitted as a literal data word. The block sits between the packet source (DMA/framer) and tag-consuming user logic.

Parameters:
DWIDTH, 64, data width of both streams and of tag_escape
TYPE_WIDTH, 7, tag type field width; header bits [TYPE_WIDTH-1:0]
LEN_WIDTH, 4, payload length field; header bits [TYPE_WIDTH+LEN_WIDTH-1:TYPE_WIDTH] hold (words-1)
CNT_WIDTH, 32, width of tag_count

Ports:
clk  in  1  clock
areset  in  1  asynchronous reset, active-high
use_tags  in  1  1 = parse escapes; 0 = transparent pass-through
tag_escape  in  DWIDTH  escape word value
s_axi_data  in  DWIDTH  input data
s_axi_valid  in  1  input valid
s_axi_ready  out  1  input ready
s_axi_last  in  1  input end of packet
m_axi_data  out  DWIDTH  output data
m_axi_valid  out  1  output valid
m_axi_ready  in  1  output ready
m_axi_last  out  1  output end of packet
m_axi_tag_valid  out  1  output word is tag payload
m_axi_tag_type  out  TYPE_WIDTH  tag type; 0 when tag_valid=0
m_axi_tag_first  out  1  first payload word of a tag
tag_count  out  CNT_WIDTH  completed tags, wraps modulo 2^CNT_WIDTH
err_truncated  out  1  one-cycle pulse on a tag aborted by s_axi_last

Behaviour:
- Reset values: all m_axi_* outputs 0, tag_count 0, err_truncated 0, state PASS.
- Output stage is a single register: s_axi_ready = !m_axi_valid || m_axi_ready.
- An input beat is accepted when s_axi_valid && s_axi_ready.
- Latency is 1 cycle. Full throughput with no bubbles.
- m_axi_* outputs hold stable while m_axi_valid && !m_axi_ready.
- Input words that are consumed without producing output (escape, non-literal header) leave the output register empty, or let it drain.
- PASS state:
  - use_tags=0 or word != tag_escape: emit word unchanged with tag_valid=0 and last = s_axi_last.
  - use_tags=1 and word == tag_escape: consume it, no output, go to HDR.
- HDR state (next accepted word):
  - Type = hdr[TYPE_WIDTH-1:0]; len = hdr field + 1.
  - Type==0: emit tag_escape as a literal data word (tag_valid=0, last = s_axi_last), return to PASS.
  - Type!=0: consume the header, latch type, load remaining = len, go to PAYLOAD.
- PAYLOAD state:
  - Each word is emitted with tag_valid=1, tag_type = latched type, tag_first=1 on the first word only, last = s_axi_last.
  - remaining decrements per word. On the word where remaining==1: tag_count++, return to PASS.
  - Escape-valued words in PAYLOAD are payload, not escapes.
- Truncation:
  - s_axi_last on the escape word or on a type!=0 header: tag aborted, no output, err_truncated pulses, state PASS.
  - s_axi_last on a payload word before the final one: the word is emitted with last=1 and tag_valid=1, err_truncated pulses, tag_count is not incremented, state PASS.
- use_tags is sampled only in PASS. A tag in progress completes regardless of later use_tags changes.
- tag_escape must be static while in HDR/PAYLOAD.
- areset mid-tag: immediate return to PASS. The output register is cleared and the partial tag is discarded.
- Backpressure never drops or duplicates words; state advances only on accepted beats.

Test Plan:
- use_tags=0, words 1,2,0xAAAA..AA(last) -> identical 3 words out, tag_valid=0, last on word 3, tag_count=0.
- use_tags=1, escape=0xAAAA..AA, stream 5, ESC, hdr type=3 len-1=2, P0, P1, P2(last) -> out 5 (tag_valid=0); P0 (tag_valid=1, type=3, first=1); P1, P2 (first=0); last on P2; tag_count=1.
- ESC, hdr type=0, 7 -> out 0xAAAA..AA (tag_valid=0), then 7; tag_count unchanged.
- ESC, hdr type=5 len-1=3, P0, P1(last) -> P0, P1 out with tag_valid=1 and last on P1; err_truncated pulses once; tag_count unchanged; next plain word passes with tag_valid=0.
- Random m_axi_ready (50%) over 1000 mixed words with 100 tags -> output matches golden model exactly; tag_count=100.
- Assert areset while in PAYLOAD with 2 words remaining -> m_axi_valid=0 during reset; next word after reset is treated as PASS data.
